alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational ALU (3-bit operation, 32-bit left/right, 32-bit result) between NUM_REQ requesters.
- Arbitration is round-robin. Each requester uses a valid/ready handshake.
- The result is registered and returned on one response channel, tagged with the requester ID.
- Sits between issue logic (e.g. multiple pipeline lanes or a microsequencer) and the shared ALU datapath.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 1, width of resp_id; must equal max(1, clog2(NUM_REQ)).

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset_n  input  1  synchronous, active-low reset, sampled on posedge clock.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester grant; at most one bit high per cycle.
- req_op  input  3*NUM_REQ  operation for requester i, bits [3i+2:3i].
- req_left  input  32*NUM_REQ  left operand for requester i, bits [32i+31:32i].
- req_right  input  32*NUM_REQ  right operand for requester i, same slicing.
- resp_valid  output  1  registered result available.
- resp_ready  input  1  consumer accepts the result.
- resp_data  output  32  registered ALU result.
- resp_id  output  ID_W  index of the requester that produced resp_data.

Behaviour:
- Reset (reset_n low at posedge):
  - resp_valid=0, resp_data=0, resp_id=0.
  - Priority pointer=0; state=IDLE.
  - req_ready is all-zero during any cycle in which reset_n is low.
- States:
  - IDLE: no result held.
  - FULL: result held, resp_valid=1.
- can_accept = (state==IDLE) || resp_ready.
  - In FULL, this allows a new issue in the same cycle the held result is consumed, giving one result per cycle.
- Grant (combinational):
  - If can_accept, req_ready has a single bit set for the first requester with req_valid=1, searching from the priority pointer upward and wrapping modulo NUM_REQ.
  - Otherwise req_ready=0.
  - req_ready never depends on that requester's own req_valid beyond selection; there are no combinational paths from resp_data.
- Transfer: occurs when req_valid[i] && req_ready[i]. The ALU is fed req_op/left/right of the granted index. At the posedge:
  - resp_data <= ALU result; resp_id <= i; resp_valid <= 1; state <= FULL.
  - Priority pointer <= (i+1) mod NUM_REQ.
- Latency: exactly 1 cycle from request handshake to resp_valid.
- FULL with resp_ready=1 and no granted request: resp_valid <= 0, state <= IDLE. resp_data and resp_id hold their last values.
- FULL with resp_ready=0: resp_valid, resp_data and resp_id are held stable; req_ready=0 (backpressure).
- Pointer advances only on a transfer. An idle cycle or a cycle with no valid request leaves it unchanged.
- A single active requester gets back-to-back grants every cycle while the consumer keeps resp_ready=1.
- Operands are sampled only on the handshake cycle. Changing operands later does not affect the held result.
- Reset mid-operation: a held result is discarded (resp_valid=0 next cycle), the pointer returns to 0, and no grant is issued in the reset cycle.
- Operation codes pass to the ALU unmodified. The ALU defines the result for every code, so there is no illegal-op handling here.

Decomposition:
- Shared package alu_pkg:
  - ALU operation localparams: OP_SLL=3'd0, OP_SRL=3'd1, OP_SLT=3'd2, plus the remaining codes.
  - Data width constant XLEN=32.
- Instantiate the existing ALU module unchanged.
- One natural sub-module: rr_grant. A combinational round-robin picker taking valid and pointer, returning a one-hot grant and the encoded index. It is reusable by other arbiters.

Test Plan:
- Reset:
  - Stimulus: hold reset_n=0 for 2 cycles with req_valid=2'b11.
  - Required: req_ready=0, resp_valid=0, resp_data=0, resp_id=0.
  - After release, the first grant goes to requester 0.
- Single request latency:
  - Stimulus: req 0 with op=OP_SLL, left=32'h00000001, right=32'd16.
  - Required: resp_valid next cycle, resp_data=32'h00010000, resp_id=0.
- Round-robin contention:
  - Stimulus: both requesters valid continuously with resp_ready=1. Req0 is op=OP_SRL, left=32'h7fff0003, right=8. Req1 is op=OP_SLT, left=10, right=20.
  - Required: grants alternate 0,1,0,1. Responses alternate 32'h007fff00 (id 0) and 32'h00000001 (id 1), one per cycle.
- Backpressure:
  - Stimulus: hold resp_ready=0 for 3 cycles while req1 is valid.
  - Required: resp_data/resp_id stay stable, req_ready=0 throughout. Raising resp_ready grants req1 in that same cycle and delivers its result the following cycle.
- Signed compare passthrough:
  - Stimulus: req1 with op=OP_SLT, left=32'hffffffff, right=32'h10.
  - Required: resp_data=1, resp_id=1.
- Reset mid-operation:
  - Stimulus: pulse reset_n low while resp_valid=1 and resp_ready=0.
  - Required: resp_valid=0 next cycle, the held result is dropped, and the pointer returns to 0 (the next contention grants req0 first).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the arbiter that feeds it.
// This package holds the operation codes, the datapath width and the arbiter state type.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SLT = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;

    typedef enum logic {
        ST_IDLE,
        ST_FULL
    } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU. Every 3-bit opcode produces a defined result.
// Shift amounts come from the low five bits of the right operand.
module alu
    import alu_pkg::*;
(
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] left,
    input  logic [XLEN-1:0] right,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_SLL: result = left << right[4:0];
            OP_SRL: result = left >> right[4:0];
            OP_SLT: result = {{(XLEN-1){1'b0}}, ($signed(left) < $signed(right))};
            OP_ADD: result = left + right;
            OP_SUB: result = left - right;
            OP_AND: result = left & right;
            OP_OR:  result = left | right;
            OP_XOR: result = left ^ right;
        endcase
    end

endmodule

// File: rtl/rr_grant.sv
// Combinational round-robin picker. It searches upward from ptr, wrapping modulo N,
// and returns a one-hot grant for the first valid requester together with its encoded index.
module rr_grant #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// This module shares one ALU between NUM_REQ requesters using round-robin arbitration.
// The result is registered and returned on a single response channel tagged with the requester id.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [3*NUM_REQ-1:0]      req_op,
    input  logic [XLEN*NUM_REQ-1:0]   req_left,
    input  logic [XLEN*NUM_REQ-1:0]   req_right,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [XLEN-1:0]           resp_data,
    output logic [ID_W-1:0]           resp_id
);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic [ID_W-1:0] id_q, id_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic               can_accept;
    logic               transfer;
    logic [2:0]         sel_op;
    logic [XLEN-1:0]    sel_left;
    logic [XLEN-1:0]    sel_right;
    logic [XLEN-1:0]    alu_result;

    rr_grant #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_rr_grant (
        .valid (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // A held result that is consumed this cycle frees the register for a new issue.
    assign can_accept = (state_q == ST_IDLE) || resp_ready;
    assign transfer   = reset_n && can_accept && grant_any;
    assign req_ready  = (reset_n && can_accept) ? grant : '0;

    assign sel_op    = req_op[int'(grant_idx)*3 +: 3];
    assign sel_left  = req_left[int'(grant_idx)*XLEN +: XLEN];
    assign sel_right = req_right[int'(grant_idx)*XLEN +: XLEN];

    alu u_alu (
        .op     (sel_op),
        .left   (sel_left),
        .right  (sel_right),
        .result (alu_result)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        id_d    = id_q;
        if (transfer) begin
            state_d = ST_FULL;
            data_d  = alu_result;
            id_d    = grant_idx;
            ptr_d   = (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + ID_W'(1);
        end else if (state_q == ST_FULL && resp_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
        end
    end

    assign resp_valid = (state_q == ST_FULL);
    assign resp_data  = data_q;
    assign resp_id    = id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter with two requesters.
// A transaction-level reference model predicts grants and the response stream.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N   = 2;
    localparam int IDW = 1;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [3*N-1:0]    req_op;
    logic [32*N-1:0]   req_left;
    logic [32*N-1:0]   req_right;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic [IDW-1:0]    resp_id;

    typedef struct {
        logic [31:0] data;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   model_ptr = 0;
    bit   model_full = 1'b0;

    alu_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_left   (req_left),
        .req_right  (req_right),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int signed sa;
        int signed sb_v;
        sa   = a;
        sb_v = b;
        case (op)
            OP_SLL:  return a << b[4:0];
            OP_SRL:  return a >> b[4:0];
            OP_SLT:  return (sa < sb_v) ? 32'd1 : 32'd0;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; the model predicts the grant and queues the response.
    task automatic drive_cycle(input logic rst_n, input logic [N-1:0] v, input logic [3*N-1:0] op,
                               input logic [32*N-1:0] l, input logic [32*N-1:0] r, input logic rr);
        int g;
        int idx;
        logic [N-1:0] exp_ready;
        @(posedge clock);
        #2;
        check("resp_valid", {31'd0, resp_valid}, {31'd0, model_full});
        reset_n    = rst_n;
        req_valid  = v;
        req_op     = op;
        req_left   = l;
        req_right  = r;
        resp_ready = rr;
        #1;
        g = -1;
        exp_ready = '0;
        if (rst_n && (!model_full || rr)) begin
            for (int k = 0; k < N; k++) begin
                idx = (model_ptr + k) % N;
                if (g < 0 && v[idx]) g = idx;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        if (!rst_n) begin
            model_full = 1'b0;
            model_ptr  = 0;
            sb.delete();
        end else if (g >= 0) begin
            sb.push_back('{ref_alu(op[3*g +: 3], l[32*g +: 32], r[32*g +: 32]), g});
            model_ptr  = (g + 1) % N;
            model_full = 1'b1;
        end else if (model_full && rr) begin
            model_full = 1'b0;
        end
    endtask

    // Monitor: compares each presented response against the queue head and pops it on consumption.
    initial begin
        forever begin
            @(negedge clock);
            if (reset_n === 1'b1 && resp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("[TB] FAIL unexpected_resp: got data %h id %0d, expected no response", resp_data, resp_id);
                end else begin
                    check("resp_data", resp_data, sb[0].data);
                    check("resp_id", 32'(resp_id), sb[0].id);
                    if (resp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic [3*N-1:0]  op;
        logic [32*N-1:0] l;
        logic [32*N-1:0] r;
        logic [31:0]     rnd;
        reset_n    = 1'b0;
        req_valid  = '0;
        req_op     = '0;
        req_left   = '0;
        req_right  = '0;
        resp_ready = 1'b0;

        // Reset held for two cycles with both requesters asking.
        drive_cycle(1'b0, 2'b11, '0, '0, '0, 1'b1);
        drive_cycle(1'b0, 2'b11, '0, '0, '0, 1'b1);
        check("reset_resp_data", resp_data, 32'd0);
        check("reset_resp_id", 32'(resp_id), 32'd0);

        // First grant after release goes to requester 0.
        drive_cycle(1'b1, 2'b11, {OP_ADD, OP_SLL}, {32'd5, 32'h1}, {32'd6, 32'd16}, 1'b1);

        // Contention: grants alternate with one response per cycle.
        op = {OP_SLT, OP_SRL};
        l  = {32'd10, 32'h7fff0003};
        r  = {32'd20, 32'd8};
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 2'b11, op, l, r, 1'b1);
        drive_cycle(1'b1, 2'b00, op, l, r, 1'b1);

        // Single request latency.
        drive_cycle(1'b1, 2'b01, {OP_ADD, OP_SLL}, {32'd0, 32'h1}, {32'd0, 32'd16}, 1'b1);
        drive_cycle(1'b1, 2'b00, '0, '0, '0, 1'b1);

        // Backpressure with req1 waiting, then the signed compare passthrough.
        drive_cycle(1'b1, 2'b01, {OP_SLT, OP_XOR}, {32'hffffffff, 32'h1234}, {32'h10, 32'hff}, 1'b1);
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b1, 2'b10, {OP_SLT, OP_ADD}, {32'hffffffff, 32'(i)}, {32'h10, 32'd7}, 1'b0);
        drive_cycle(1'b1, 2'b10, {OP_SLT, OP_ADD}, {32'hffffffff, 32'd9}, {32'h10, 32'd7}, 1'b1);
        drive_cycle(1'b1, 2'b00, '0, '0, '0, 1'b1);

        // Reset while a result is held under backpressure.
        drive_cycle(1'b1, 2'b10, {OP_OR, OP_AND}, {32'hf0, 32'h0}, {32'h0f, 32'h0}, 1'b0);
        drive_cycle(1'b1, 2'b00, '0, '0, '0, 1'b0);
        drive_cycle(1'b0, 2'b00, '0, '0, '0, 1'b0);
        drive_cycle(1'b1, 2'b11, {OP_SUB, OP_ADD}, {32'd3, 32'd1}, {32'd5, 32'd2}, 1'b1);
        drive_cycle(1'b1, 2'b11, {OP_SUB, OP_ADD}, {32'd3, 32'd1}, {32'd5, 32'd2}, 1'b1);

        // Random traffic with occasional resets and random backpressure.
        for (int i = 0; i < 400; i++) begin
            rnd = $urandom;
            op  = rnd[5:0];
            l   = {$urandom, $urandom};
            r   = {$urandom, $urandom};
            if (rnd[8]) r = r & {32'h1f, 32'h1f};
            drive_cycle(($urandom_range(0, 39) != 0), 2'($urandom_range(0, 3)), op, l, r,
                        ($urandom_range(0, 3) != 0));
        end

        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 2'b00, '0, '0, '0, 1'b1);
        @(posedge clock);
        #2;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
